// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 16-way round-robin arbiter.
// Imported by the priority encoder and the arbiter top level.
package rr_arb_pkg;

    localparam int NREQ  = 16;
    localparam int IDX_W = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [IDX_W-1:0] IDLE_IDX = 4'd0;

    // One-hot vector with only bit idx set.
    function automatic logic [NREQ-1:0] onehot(
        input logic [IDX_W-1:0] idx
    );
        return NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/prio_enc_16.sv
// MSB-first 16-to-4 priority encoder.
// valid_o is high when any input bit is set; idx_o is 0 otherwise.
module prio_enc_16
    import rr_arb_pkg::*;
(
    input  logic [NREQ-1:0]  vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Ascending scan: the last hit, i.e. the highest set bit, wins.
    always_comb begin
        idx_o   = IDLE_IDX;
        valid_o = |vec_i;
        for (int i = 0; i < NREQ; i++) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters with a bounded hold time.
// Grants rotate in descending index order, wrapping 0 -> 15.
module rr_arbiter_16
    import rr_arb_pkg::*;
#(
    parameter  int unsigned MAX_HOLD = 8,
    localparam int unsigned CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic [CNT_W-1:0] hold_cnt
);

    state_t           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NREQ-1:0]  req_eff;
    logic [NREQ-1:0]  mask;
    logic [NREQ-1:0]  masked;
    logic [IDX_W-1:0] m_idx, u_idx, winner;
    logic             m_valid, u_valid;
    logic             others;
    logic             owner_req;
    logic             at_max;

    // While granted, the owner is excluded so a forced release
    // can never hand the grant straight back to it.
    assign req_eff   = (state_q == GRANT) ? (req & ~gnt_q) : req;
    assign mask      = (NREQ'(1) << last_q) - NREQ'(1);
    assign masked    = req_eff & mask;
    assign others    = |(req & ~gnt_q);
    assign owner_req = req[idx_q];
    assign at_max    = (cnt_q == CNT_W'(MAX_HOLD));

    prio_enc_16 u_enc_masked (
        .vec_i   (masked),
        .idx_o   (m_idx),
        .valid_o (m_valid)
    );

    prio_enc_16 u_enc_plain (
        .vec_i   (req_eff),
        .idx_o   (u_idx),
        .valid_o (u_valid)
    );

    // Below last owner first; otherwise wrap to the top.
    assign winner = m_valid ? m_idx : u_idx;

    // Next-state: grant, handover, forced release or hold.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (en && u_valid) begin
                    state_d = GRANT;
                    gnt_d   = onehot(winner);
                    idx_d   = winner;
                    last_d  = winner;
                    cnt_d   = CNT_W'(1);
                end
            end
            GRANT: begin
                if ((!owner_req || at_max) && en && others) begin
                    gnt_d  = onehot(winner);
                    idx_d  = winner;
                    last_d = winner;
                    cnt_d  = CNT_W'(1);
                end else if (!owner_req) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    idx_d   = IDLE_IDX;
                    cnt_d   = '0;
                end else if (!at_max) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = IDLE_IDX;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= IDLE_IDX;
            last_q  <= IDLE_IDX;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = (state_q == GRANT);
    assign hold_cnt  = cnt_q;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Bench for rr_arbiter_16: directed scenarios with literal
// expectations plus a per-cycle reference model and random traffic.
module tb_rr_arbiter_16;

    localparam int MAXH  = 8;
    localparam int CW    = $clog2(MAXH + 1);
    localparam int BOUND = 15 * MAXH + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [15:0]   req = '0;
    logic [15:0]   gnt;
    logic [3:0]    gnt_idx;
    logic          gnt_valid;
    logic [CW-1:0] hold_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rr_arbiter_16 #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .hold_cnt  (hold_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: owner (-1 = none), last winner, hold length.
    typedef struct {
        int owner;
        int last;
        int hold;
    } mstate_t;

    mstate_t m = '{-1, 0, 0};

    // Walk the ring downward from the last winner, wrapping 0 -> 15;
    // the last winner itself is the final candidate.
    function automatic int pick(input logic [15:0] v, input int last);
        for (int k = 1; k <= 16; k++) begin
            int i;
            i = (last - k + 32) % 16;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic mstate_t step(input mstate_t s,
                                     input logic [15:0] r,
                                     input logic e);
        mstate_t     n;
        logic [15:0] oth;
        int          w;
        n   = s;
        oth = r;
        if (s.owner >= 0) oth[s.owner] = 1'b0;
        if (s.owner < 0) begin
            if (e && r != 0) begin
                w = pick(r, s.last);
                n = '{w, w, 1};
            end
        end else if (!r[s.owner] || s.hold == MAXH) begin
            if (e && oth != 0) begin
                w = pick(oth, s.last);
                n = '{w, w, 1};
            end else if (!r[s.owner]) begin
                n.owner = -1;
                n.hold  = 0;
            end
        end else begin
            n.hold = s.hold + 1;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '{-1, 0, 0};
        else     m <= step(m, req, en);
    end

    // Per-cycle compare against the model plus invariants.
    initial begin
        logic [15:0] prev_gnt;
        logic [15:0] e_gnt;
        int          waitc [16];
        int          wmax;
        prev_gnt = '0;
        foreach (waitc[i]) waitc[i] = 0;
        forever begin
            @(posedge clk);
            #2;
            e_gnt = (m.owner < 0) ? 16'h0 : (16'h1 << m.owner);
            chk("m_gnt", gnt, e_gnt);
            chk("m_idx", gnt_idx, (m.owner < 0) ? 0 : m.owner);
            chk("m_valid", gnt_valid, m.owner >= 0);
            chk("m_hold", hold_cnt, m.hold);
            chk("onehot0", $onehot0(gnt), 1);
            chk("valid_or", gnt_valid, |gnt);
            if (gnt != 0 && gnt != prev_gnt)
                chk("edge_req", gnt & req, gnt);
            wmax = 0;
            for (int i = 0; i < 16; i++) begin
                if (req[i] && !gnt[i] && en && !rst)
                    waitc[i]++;
                else
                    waitc[i] = 0;
                if (waitc[i] > wmax) wmax = waitc[i];
            end
            chk("starve", wmax > BOUND, 0);
            prev_gnt = gnt;
        end
    end

    task automatic do_reset();
        req = '0;
        en  = 1'b1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_idx", gnt_idx, 0);
        chk("rst_valid", gnt_valid, 0);
        chk("rst_hold", hold_cnt, 0);

        // First grant goes to the MSB, then same-edge handover.
        req = 16'h8001;
        en  = 1'b1;
        @(negedge clk);
        chk("t1_gnt", gnt, 16'h8000);
        chk("t1_idx", gnt_idx, 15);
        chk("t1_valid", gnt_valid, 1);
        chk("t1_hold", hold_cnt, 1);
        req = 16'h0001;
        @(negedge clk);
        chk("t1_hand_gnt", gnt, 16'h0001);
        chk("t1_hand_idx", gnt_idx, 0);
        chk("t1_hand_hold", hold_cnt, 1);

        // Full load: 15 down to 0 then 15 again, 8 cycles each.
        do_reset();
        req = 16'hFFFF;
        for (int n = 0; n < 17; n++) begin
            for (int h = 1; h <= MAXH; h++) begin
                @(negedge clk);
                chk("rr_idx", gnt_idx, (31 - n) % 16);
                chk("rr_hold", hold_cnt, h);
            end
        end

        // Lone requester holds forever; counter saturates.
        do_reset();
        req = 16'h0010;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("solo_idx", gnt_idx, 4);
            chk("solo_hold", hold_cnt, (k < MAXH) ? k : MAXH);
        end

        // en=0 blocks re-arbitration and new grants.
        do_reset();
        req = 16'h0080;
        @(negedge clk);
        chk("en_idx0", gnt_idx, 7);
        en  = 1'b0;
        req = 16'h0480;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("en_hold_idx", gnt_idx, 7);
        end
        chk("en_hold_sat", hold_cnt, MAXH);
        req = 16'h0400;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("en_idle_gnt", gnt, 0);
            chk("en_idle_valid", gnt_valid, 0);
        end
        en = 1'b1;
        @(negedge clk);
        chk("en_back_gnt", gnt, 16'h0400);
        chk("en_back_idx", gnt_idx, 10);

        // Asynchronous reset mid-grant clears before any edge.
        do_reset();
        req = 16'h0200;
        repeat (3) @(negedge clk);
        chk("ar_idx9", gnt_idx, 9);
        #1 rst = 1'b1;
        #1;
        chk("ar_gnt", gnt, 0);
        chk("ar_idx", gnt_idx, 0);
        chk("ar_valid", gnt_valid, 0);
        chk("ar_hold", hold_cnt, 0);
        rst = 1'b0;
        req = 16'h0600;
        @(negedge clk);
        chk("ar_after", gnt_idx, 10);

        // Last winner 9 would pick 8 from 0x0300; reset must give 9.
        req = 16'h0000;
        @(negedge clk);
        req = 16'h0200;
        @(negedge clk);
        chk("ar2_idx9", gnt_idx, 9);
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        req = 16'h0300;
        @(negedge clk);
        chk("ar2_last", gnt_idx, 9);

        // Random traffic with sticky request bits.
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            en = ($urandom_range(0, 15) != 0);
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            end
        end
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_16.md
Name: rr_arbiter_16

Overview:
- Round-robin arbiter sharing one 16-input priority-encoded resource between 16 requesters.
- Uses the team's MSB-first 16-to-4 priority encoding, with a rotating mask so that no requester starves.
- Registered one-hot grant, index and valid outputs, with a bounded hold time per grant.
- Sits in front of the shared resource; downstream logic consumes gnt_idx as the owner select.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one owner keeps the grant while others wait. Legal range 2..255.
- CNT_W, $clog2(MAX_HOLD+1): hold-counter width. Derived; do not override.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  arbitration enable. Low blocks new grants; an existing grant still completes.
- req  in  16  request vector; bit i is requester i; level-sensitive.
- gnt  out  16  one-hot grant, registered.
- gnt_idx  out  4  index of the granted requester; 0 when gnt_valid=0.
- gnt_valid  out  1  high while any grant is held.
- hold_cnt  out  CNT_W  cycles the current owner has held the grant; 0 when idle.

Behaviour:
- Reset (async, rst=1): gnt=0, gnt_idx=0, gnt_valid=0, hold_cnt=0, last_idx=0, state=IDLE. Takes effect immediately, including mid-grant.
- Arbitration function (combinational):
  - masked = req_eff & ((16'h1 << last_idx) - 1).
  - If masked != 0, the winner is the highest set bit of masked; otherwise it is the highest set bit of req_eff.
  - With last_idx=0 the mask is empty, so plain MSB-first priority applies.
  - req_eff = req, or req & ~gnt during a forced release.
- States:
  - IDLE: if en && |req, then at the next edge go to GRANT with gnt = onehot(winner), gnt_idx = winner, gnt_valid=1, hold_cnt=1, last_idx=winner. Latency is one cycle from req sampled to gnt visible. Otherwise stay in IDLE.
  - GRANT, normal release: req[gnt_idx]=0.
    - If en && (req & ~gnt) != 0, re-arbitrate at that same edge (back-to-back, no idle bubble). Load new gnt/idx/last_idx; hold_cnt=1.
    - Otherwise go to IDLE: gnt=0, gnt_idx=0, gnt_valid=0, hold_cnt=0. last_idx is retained.
  - GRANT, forced release: req[gnt_idx]=1 && hold_cnt==MAX_HOLD && en && (req & ~gnt) != 0. Re-arbitrate with req_eff = req & ~gnt; the current owner loses the grant at that edge. hold_cnt=1.
  - GRANT, otherwise: keep the grant; hold_cnt increments, saturating at MAX_HOLD. A single requester may hold indefinitely if no other requester is present or en=0.
- en=0 in GRANT: no re-arbitration. The owner keeps the grant until its req drops, then the block goes to IDLE.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_idx matches gnt.
  - gnt_valid == |gnt.
  - gnt[i]=1 only if req[i] was 1 at the granting edge.
- Wrap-around: with last_idx=0 and a mask miss, the search restarts from bit 15. Fairness order is descending index, wrapping 0 -> 15.
- Simultaneous drop of the owner's req and arrival of new reqs: same-edge handover as above.
- No combinational path from req to any output.

Decomposition:
- Package rr_arb_pkg:
  - NREQ=16, IDX_W=4.
  - typedef state_t {IDLE, GRANT}.
  - IDLE_IDX=4'd0.
- Sub-module prio_enc_16: combinational 16-bit in -> 4-bit idx plus valid, MSB-first. It is instantiated twice, once for the masked and once for the unmasked vector.
- The top level holds the FSM, hold counter and last_idx register.

Test Plan:
- Reset then req=16'h8001, en=1 -> one cycle later gnt=16'h8000, gnt_idx=15, gnt_valid=1, hold_cnt=1. Drop req[15] -> next edge gnt=16'h0001, gnt_idx=0, with no idle cycle.
- req held at 16'hFFFF, MAX_HOLD=8 -> owners 15,14,13,...,0,15 in sequence, each for exactly 8 cycles; hold_cnt counts 1..8 then returns to 1.
- req=16'h0010 only, held for 20 cycles -> gnt_idx=4 throughout; hold_cnt saturates at 8; no forced release.
- Grant held by idx 7, then en=0 and req=16'h0480 -> idx 7 keeps the grant past MAX_HOLD. When req[7] drops -> IDLE, gnt=0, and no grant to 10 until en=1.
- Assert rst mid-grant (gnt_idx=9) -> outputs clear asynchronously, before the next clk edge. After release with req=16'h0600 -> gnt_idx=10, showing last_idx was reset.
- Throughout random req/en for 10k cycles, check:
  - the one-hot invariant holds;
  - gnt[i] implies req[i] was high at the granting edge;
  - no requester that holds req continuously waits more than 15*MAX_HOLD+1 cycles.
